// File: rtl/hazard_pkg.sv
// Shared encodings, shadow-entry type and helpers for the hazard controller.
package hazard_pkg;

  localparam int HZ_REG_AW = 5;
  localparam int HZ_TW     = 2;

  localparam int N_STG = 3;
  localparam int STG_E = 0;
  localparam int STG_M = 1;
  localparam int STG_W = 2;

  // D-stage forward selects
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  // E-stage forward selects
  localparam logic [1:0] FWD_PIPE = 2'd0;
  localparam logic [1:0] FWD_EX_M = 2'd1;
  localparam logic [1:0] FWD_EX_W = 2'd2;

  typedef struct packed {
    logic [HZ_REG_AW-1:0] dst;
    logic [HZ_TW-1:0]     tnew;
  } shadow_t;

  function automatic logic [HZ_TW-1:0] sat_dec(input logic [HZ_TW-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  // Oldest-producer-last priority: the youngest ready copy of a register wins.
  function automatic logic [1:0] pick_fwd_d(input logic [N_STG-1:0] ready);
    if (ready[STG_E])      return FWD_E;
    else if (ready[STG_M]) return FWD_M;
    else if (ready[STG_W]) return FWD_W;
    else                   return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_md_busy.sv
// Multiply/divide busy counter: loads the op latency on start, counts down to 0.
module hazard_md_busy
  import hazard_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (start) begin
      count_d = is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign busy  = (count_q != '0);
  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl_md.sv
// Hazard controller for the 5-stage pipeline with shadow Tnew tracking and MD busy stall.
// Optional stall statistics counters are built when HAZ_STATS_EN is defined.
module hazard_ctrl_md
  import hazard_pkg::*;
#(
  parameter int REG_AW   = HZ_REG_AW,
  parameter int TW       = HZ_TW,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs_D,
  input  logic [REG_AW-1:0] rt_D,
  input  logic              rs_use_D,
  input  logic              rt_use_D,
  input  logic [TW-1:0]     tuse_rs_D,
  input  logic [TW-1:0]     tuse_rt_D,
  input  logic [REG_AW-1:0] dst_D,
  input  logic [TW-1:0]     tnew_D,
  input  logic              md_use_D,
  input  logic [REG_AW-1:0] rs_E,
  input  logic [REG_AW-1:0] rt_E,
  input  logic [REG_AW-1:0] rt_M,
  input  logic              md_start_E,
  input  logic              md_div_E,
  output logic [1:0]        fwd_rs_D,
  output logic [1:0]        fwd_rt_D,
  output logic [1:0]        fwd_a_E,
  output logic [1:0]        fwd_b_E,
  output logic              fwd_wd_M,
  output logic              stall,
  output logic              pc_en,
  output logic              fd_en,
  output logic              flush_E,
  output logic              md_busy
`ifdef HAZ_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       md_stall_cnt
`endif
);

  shadow_t sh_q [N_STG];
  shadow_t sh_d [N_STG];

  logic [N_STG-1:0] rs_hit, rt_hit;
  logic [N_STG-1:0] rs_late, rt_late;
  logic [N_STG-1:0] rs_ready, rt_ready;
  logic             data_stall;
  logic             md_stall;
  logic             md_busy_w;
  logic [CNT_W-1:0] md_count;

  hazard_md_busy #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_md_busy (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start_E),
    .is_div (md_div_E),
    .busy   (md_busy_w),
    .count  (md_count)
  );

  // Per-stage comparison of D sources against the shadow destinations.
  generate
    for (genvar gi = 0; gi < N_STG; gi++) begin : g_stage
      assign rs_hit[gi]   = rs_use_D && (rs_D != '0) && (rs_D == sh_q[gi].dst);
      assign rt_hit[gi]   = rt_use_D && (rt_D != '0) && (rt_D == sh_q[gi].dst);
      assign rs_late[gi]  = rs_hit[gi] && (sh_q[gi].tnew > tuse_rs_D);
      assign rt_late[gi]  = rt_hit[gi] && (sh_q[gi].tnew > tuse_rt_D);
      assign rs_ready[gi] = rs_hit[gi] && (sh_q[gi].tnew == '0);
      assign rt_ready[gi] = rt_hit[gi] && (sh_q[gi].tnew == '0);
    end
  endgenerate

  assign data_stall = (|rs_late) | (|rt_late);
  assign md_stall   = md_use_D & ((md_count != '0) | md_start_E);
  assign stall      = data_stall | md_stall;
  assign pc_en      = ~stall;
  assign fd_en      = ~stall;
  assign flush_E    = stall;
  assign md_busy    = md_busy_w;

  assign fwd_rs_D = pick_fwd_d(rs_ready);
  assign fwd_rt_D = pick_fwd_d(rt_ready);

  always_comb begin
    fwd_a_E = FWD_PIPE;
    if ((rs_E != '0) && (rs_E == sh_q[STG_M].dst) && (sh_q[STG_M].tnew == '0)) begin
      fwd_a_E = FWD_EX_M;
    end else if ((rs_E != '0) && (rs_E == sh_q[STG_W].dst)) begin
      fwd_a_E = FWD_EX_W;
    end
  end

  always_comb begin
    fwd_b_E = FWD_PIPE;
    if ((rt_E != '0) && (rt_E == sh_q[STG_M].dst) && (sh_q[STG_M].tnew == '0)) begin
      fwd_b_E = FWD_EX_M;
    end else if ((rt_E != '0) && (rt_E == sh_q[STG_W].dst)) begin
      fwd_b_E = FWD_EX_W;
    end
  end

  assign fwd_wd_M = (rt_M != '0) && (rt_M == sh_q[STG_W].dst);

  // A stalled D instruction is replaced by a bubble in E while M and W keep draining.
  always_comb begin
    sh_d[STG_W] = '{dst: sh_q[STG_M].dst, tnew: sat_dec(sh_q[STG_M].tnew)};
    sh_d[STG_M] = '{dst: sh_q[STG_E].dst, tnew: sat_dec(sh_q[STG_E].tnew)};
    if (stall) begin
      sh_d[STG_E] = '0;
    end else begin
      sh_d[STG_E] = '{dst: dst_D, tnew: tnew_D};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_STG; i++) begin
        sh_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_STG; i++) begin
        sh_q[i] <= sh_d[i];
      end
    end
  end

`ifdef HAZ_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] md_stall_cnt_q, md_stall_cnt_d;

  always_comb begin
    stall_cnt_d    = stall_cnt_q + {31'd0, stall};
    md_stall_cnt_d = md_stall_cnt_q + {31'd0, md_stall};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q    <= '0;
      md_stall_cnt_q <= '0;
    end else begin
      stall_cnt_q    <= stall_cnt_d;
      md_stall_cnt_q <= md_stall_cnt_d;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign md_stall_cnt = md_stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_md.sv
// Directed-vector bench for hazard_ctrl_md: pipeline hazard scenarios and MD busy tracking.
module tb_hazard_ctrl_md;

  logic       clk;
  logic       reset;
  logic [4:0] rs_D, rt_D, dst_D, rs_E, rt_E, rt_M;
  logic       rs_use_D, rt_use_D, md_use_D, md_start_E, md_div_E;
  logic [1:0] tuse_rs_D, tuse_rt_D, tnew_D;
  logic [1:0] fwd_rs_D, fwd_rt_D, fwd_a_E, fwd_b_E;
  logic       fwd_wd_M, stall, pc_en, fd_en, flush_E, md_busy;
`ifdef HAZ_STATS_EN
  logic [31:0] stall_cnt, md_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  hazard_ctrl_md dut (
    .clk        (clk),
    .reset      (reset),
    .rs_D       (rs_D),
    .rt_D       (rt_D),
    .rs_use_D   (rs_use_D),
    .rt_use_D   (rt_use_D),
    .tuse_rs_D  (tuse_rs_D),
    .tuse_rt_D  (tuse_rt_D),
    .dst_D      (dst_D),
    .tnew_D     (tnew_D),
    .md_use_D   (md_use_D),
    .rs_E       (rs_E),
    .rt_E       (rt_E),
    .rt_M       (rt_M),
    .md_start_E (md_start_E),
    .md_div_E   (md_div_E),
    .fwd_rs_D   (fwd_rs_D),
    .fwd_rt_D   (fwd_rt_D),
    .fwd_a_E    (fwd_a_E),
    .fwd_b_E    (fwd_b_E),
    .fwd_wd_M   (fwd_wd_M),
    .stall      (stall),
    .pc_en      (pc_en),
    .fd_en      (fd_en),
    .flush_E    (flush_E),
    .md_busy    (md_busy)
`ifdef HAZ_STATS_EN
    ,
    .stall_cnt    (stall_cnt),
    .md_stall_cnt (md_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic samp;
    @(negedge clk);
  endtask

  task automatic nop_d;
    rs_D = 0; rt_D = 0; rs_use_D = 0; rt_use_D = 0;
    tuse_rs_D = 0; tuse_rt_D = 0; dst_D = 0; tnew_D = 0; md_use_D = 0;
  endtask

  task automatic clr_all;
    nop_d();
    rs_E = 0; rt_E = 0; rt_M = 0; md_start_E = 0; md_div_E = 0;
  endtask

  task automatic do_reset;
    clr_all();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic test_reset;
    clr_all();
    reset = 1;
    step();
    step();
    reset = 0;
    samp();
    total++;
    if (stall !== 1'b0 || md_busy !== 1'b0 || pc_en !== 1'b1 || flush_E !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl got stall=%0b busy=%0b pc_en=%0b flush=%0b exp 0 0 1 0",
               stall, md_busy, pc_en, flush_E);
    end
    total++;
    if ({fwd_rs_D, fwd_rt_D, fwd_a_E, fwd_b_E, fwd_wd_M} !== 9'd0) begin
      bad++;
      $display("FAIL reset_fwd got %b exp 0", {fwd_rs_D, fwd_rt_D, fwd_a_E, fwd_b_E, fwd_wd_M});
    end
    $display("txn reset: stall=%0b md_busy=%0b", stall, md_busy);
  endtask

  task automatic test_load_use;
    do_reset();
    dst_D = 2; tnew_D = 2;                       // lw $2
    samp();
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL lu_lw_nostall got %0b exp 0", stall); end
    step();
    nop_d(); rs_D = 1; rt_D = 2; rs_use_D = 1; rt_use_D = 1;
    tuse_rs_D = 1; tuse_rt_D = 1; dst_D = 5; tnew_D = 1;   // add $5,$1,$2
    samp();
    total++;
    if (stall !== 1'b1 || flush_E !== 1'b1 || pc_en !== 1'b0 || fd_en !== 1'b0) begin
      bad++;
      $display("FAIL lu_stall got stall=%0b flush=%0b pc_en=%0b fd_en=%0b exp 1 1 0 0",
               stall, flush_E, pc_en, fd_en);
    end
    step();
    samp();
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL lu_release got %0b exp 0", stall); end
    step();
    nop_d(); rs_E = 1; rt_E = 2;
    samp();
    total++;
    if (fwd_b_E !== 2'd2 || fwd_a_E !== 2'd0) begin
      bad++;
      $display("FAIL lu_fwd_e got a=%0d b=%0d exp a=0 b=2", fwd_a_E, fwd_b_E);
    end
    step();
    rs_E = 5; rt_E = 0;                          // reader of $5 while add sits in M
    samp();
    total++;
    if (fwd_a_E !== 2'd1) begin bad++; $display("FAIL lu_fwd_em got %0d exp 1", fwd_a_E); end
    $display("txn load_use: fwd_a_E=%0d", fwd_a_E);
  endtask

  task automatic test_alu_branch;
    do_reset();
    dst_D = 3; tnew_D = 1;                       // addu $3
    step();
    nop_d(); rs_D = 3; rs_use_D = 1; tuse_rs_D = 0;   // beq $3
    samp();
    total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL ab_stall got %0b exp 1", stall); end
    step();
    samp();
    total++;
    if (stall !== 1'b0 || fwd_rs_D !== 2'd2) begin
      bad++;
      $display("FAIL ab_fwd got stall=%0b fwd_rs_D=%0d exp 0 2", stall, fwd_rs_D);
    end
    $display("txn alu_branch: fwd_rs_D=%0d", fwd_rs_D);
  endtask

  task automatic test_load_branch;
    do_reset();
    dst_D = 4; tnew_D = 2;                       // lw $4
    step();
    nop_d(); rt_D = 4; rt_use_D = 1; tuse_rt_D = 0;   // beq reading $4
    for (int k = 1; k <= 2; k++) begin
      samp();
      total++;
      if (stall !== 1'b1) begin bad++; $display("FAIL lb_stall%0d got %0b exp 1", k, stall); end
      step();
    end
    samp();
    total++;
    if (stall !== 1'b0 || fwd_rt_D !== 2'd3) begin
      bad++;
      $display("FAIL lb_fwd got stall=%0b fwd_rt_D=%0d exp 0 3", stall, fwd_rt_D);
    end
    $display("txn load_branch: fwd_rt_D=%0d", fwd_rt_D);
  endtask

  task automatic test_jal_jr;
    do_reset();
    dst_D = 31; tnew_D = 0;                      // jal
    step();
    nop_d(); rs_D = 31; rs_use_D = 1; tuse_rs_D = 0;  // jr $31
    samp();
    total++;
    if (stall !== 1'b0 || fwd_rs_D !== 2'd1) begin
      bad++;
      $display("FAIL jr_fwd got stall=%0b fwd_rs_D=%0d exp 0 1", stall, fwd_rs_D);
    end
    $display("txn jal_jr: fwd_rs_D=%0d", fwd_rs_D);
  endtask

  task automatic test_md_busy;
    do_reset();
    md_start_E = 1; md_div_E = 1; md_use_D = 1;  // div in E, mflo in D
    samp();
    total++;
    if (stall !== 1'b1 || md_busy !== 1'b0) begin
      bad++;
      $display("FAIL md_start got stall=%0b busy=%0b exp 1 0", stall, md_busy);
    end
    step();
    md_start_E = 0; md_div_E = 0;
    for (int k = 1; k <= 10; k++) begin
      samp();
      total++;
      if (stall !== 1'b1 || md_busy !== 1'b1) begin
        bad++;
        $display("FAIL md_div_c%0d got stall=%0b busy=%0b exp 1 1", k, stall, md_busy);
      end
      step();
    end
    samp();
    total++;
    if (stall !== 1'b0 || md_busy !== 1'b0) begin
      bad++;
      $display("FAIL md_div_release got stall=%0b busy=%0b exp 0 0", stall, md_busy);
    end
    $display("txn md_div: released after 10 busy cycles");

    // mult latency, no HI/LO reader in D
    step();
    md_start_E = 1; md_div_E = 0; md_use_D = 0;
    step();
    md_start_E = 0;
    for (int k = 1; k <= 6; k++) begin
      samp();
      total++;
      if (md_busy !== (k <= 5) || stall !== 1'b0) begin
        bad++;
        $display("FAIL md_mult_c%0d got busy=%0b stall=%0b exp %0b 0", k, md_busy, stall, (k <= 5));
      end
      step();
    end
    $display("txn md_mult: 5 busy cycles");

    // reset in the middle of a divide
    md_start_E = 1; md_div_E = 1; md_use_D = 1;
    step();
    md_start_E = 0; md_div_E = 0;
    step();
    step();
    step();
    reset = 1;                                   // cycle 4
    samp();
    total++;
    if (md_busy !== 1'b1) begin bad++; $display("FAIL md_prereset got %0b exp 1", md_busy); end
    step();
    reset = 0;
    samp();
    total++;
    if (md_busy !== 1'b0 || stall !== 1'b0 || {fwd_rs_D, fwd_rt_D, fwd_a_E, fwd_b_E} !== 8'd0) begin
      bad++;
      $display("FAIL md_reset got busy=%0b stall=%0b exp 0 0", md_busy, stall);
    end
    $display("txn md_reset: busy=%0b stall=%0b", md_busy, stall);
  endtask

  task automatic test_zero_reg;
    do_reset();
    dst_D = 0; tnew_D = 2;                       // writes $0
    step();
    nop_d(); rs_use_D = 1; rt_use_D = 1;         // reads $0 twice
    for (int k = 0; k < 2; k++) begin
      samp();
      total++;
      if (stall !== 1'b0 || {fwd_rs_D, fwd_rt_D, fwd_a_E, fwd_b_E, fwd_wd_M} !== 9'd0) begin
        bad++;
        $display("FAIL zero_reg%0d got stall=%0b fwd=%b exp 0 0", k, stall,
                 {fwd_rs_D, fwd_rt_D, fwd_a_E, fwd_b_E, fwd_wd_M});
      end
      step();
    end
    $display("txn zero_reg: no stall, no forward");
  endtask

  task automatic test_store_fwd;
    do_reset();
    dst_D = 7; tnew_D = 2;                       // lw $7
    step();
    nop_d();
    step();
    step();
    rt_M = 7;                                    // sw $7 in M, lw in W
    samp();
    total++;
    if (fwd_wd_M !== 1'b1) begin bad++; $display("FAIL st_fwd got %0b exp 1", fwd_wd_M); end
    rt_M = 6;
    samp();
    total++;
    if (fwd_wd_M !== 1'b0) begin bad++; $display("FAIL st_nofwd got %0b exp 0", fwd_wd_M); end
    $display("txn store_fwd: done");
  endtask

  initial begin
    clr_all();
    reset = 1;
    test_reset();
    test_load_use();
    test_alu_branch();
    test_load_branch();
    test_jal_jr();
    test_md_busy();
    test_zero_reg();
    test_store_fwd();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_md.md
Name: hazard_ctrl_md

Overview:
- Next-generation hazard controller for the 5-stage MIPS pipeline (F/D/E/M/W).
- Keeps its own shadow pipeline of destination register and Tnew per stage, decrementing Tnew as instructions advance, so decoders only supply D-stage Tuse/Tnew.
- Adds a multi-cycle multiply/divide busy tracker that stalls D-stage HI/LO users.
- Emits D/E/M forward selects plus stall and flush controls.

Parameters:
- REG_AW, 5, register address width; register 0 is never stalled on or forwarded.
- TW, 2, width of Tuse/Tnew fields.
- MULT_LAT, 5, busy cycles after a mult/multu start.
- DIV_LAT, 10, busy cycles after a div/divu start.
- CNT_W, 4, width of the MD busy counter; must hold max(MULT_LAT, DIV_LAT).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rs_D, rt_D  in  REG_AW  D-stage source registers
- rs_use_D, rt_use_D  in  1  source actually read by the D instruction
- tuse_rs_D, tuse_rt_D  in  TW  cycles from D until the operand is needed (0 = in D)
- dst_D  in  REG_AW  D-stage destination (0 = none)
- tnew_D  in  TW  cycles after E entry until the result exists in the pipeline register
- md_use_D  in  1  D instruction reads or writes HI/LO, or starts MD
- rs_E, rt_E  in  REG_AW  E-stage sources
- rt_M  in  REG_AW  M-stage store-data register
- md_start_E  in  1  mult/div in E this cycle
- md_div_E  in  1  started op is a divide
- fwd_rs_D, fwd_rt_D  out  2  0 = regfile, 1 = E, 2 = M, 3 = W
- fwd_a_E, fwd_b_E  out  2  0 = pipe reg, 1 = M, 2 = W
- fwd_wd_M  out  1  0 = pipe reg, 1 = W
- stall  out  1  D hazard stall
- pc_en, fd_en  out  1  equal to ~stall
- flush_E  out  1  equal to stall; inserts a bubble into D/E
- md_busy  out  1  MD counter nonzero

Behaviour:
- Shadow registers hold (dst, tnew) for E, M and W. All clear to 0 on reset.
- Every cycle:
  - M goes to W with tnew = sat_dec(tnew_M).
  - E goes to M with tnew = sat_dec(tnew_E).
  - If stall, E takes the bubble (0, 0).
  - Otherwise E takes (dst_D, tnew_D).
- Hazard match for stage X:
  - Source is used, its address is nonzero, and it equals dst_X.
  - For D sources the stage match also requires X ∈ {E, M, W}.
- Data stall: any D source matches stage X with tnew_X > tuse for that source.
- Forward D:
  - Pick the first match in priority E, M, W, among stages with tnew_X == 0.
  - If there is no such match, select 0.
- Forward E (srcA from rs_E, srcB from rt_E):
  - M if tnew_M == 0 and the register matches.
  - Else W if it matches (tnew_W is always 0 after saturation).
  - Else 0.
  - Register 0 always selects 0.
- fwd_wd_M = 1 iff rt_M is nonzero and rt_M == dst_W.
- MD tracker (sub-module):
  - On md_start_E, load MULT_LAT or DIV_LAT (reload even if already busy).
  - Otherwise decrement each cycle while nonzero.
  - MD stall = md_use_D & (busy | md_start_E).
- stall = data stall | MD stall. It is combinational from inputs and shadow state, with zero latency.
- Reset mid-operation: shadow pipe and MD counter clear on the same edge. The first cycle after reset has stall = 0 and all forward selects 0.
- Stall held over multiple cycles: E keeps receiving bubbles while M and W drain, so the stall self-releases.

Optional Feature:
- Macro: HAZ_STATS_EN.
- When defined:
  - Adds outputs stall_cnt (32 bits) and md_stall_cnt (32 bits).
  - stall_cnt increments on every cycle with stall = 1.
  - md_stall_cnt increments on cycles where the MD stall term is 1.
  - Both clear on reset and wrap at 2^32.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg:
  - Forward-select encodings: FWD_RF, FWD_E, FWD_M, FWD_W, FWD_PIPE.
  - Typedef for the shadow entry {dst, tnew}.
  - Saturating-decrement function.
- Sub-module hazard_md_busy (clk, reset, start, is_div, busy, count) holds the MD counter.

Test Plan:
- lw $2 (tnew_D=2) in D, next D is add reading $2 with tuse=1 → stall=1 for 1 cycle, flush_E=1. Two cycles later, add in E with rt_E=2 → fwd_b_E=2 (W).
- addu $3 (tnew_D=1), then beq reading $3 with tuse=0 → stall 1 cycle, then fwd_rs_D=2 (M).
- lw $4, then beq reading $4 with tuse=0 → stall exactly 2 cycles, then fwd_rt_D=3 (W).
- jal (dst=31, tnew_D=0), then jr $31 → no stall, fwd_rs_D=1 (E).
- div start in E, then mflo in D → md_busy=1 and stall held for 10 cycles, released on cycle 11. Assert reset on cycle 4 → md_busy=0 and stall=0 the next cycle.
- Instruction writing $0 (dst=0, tnew=2), then a reader of $0 → no stall, all forward selects 0.
